stack_ctrl: RTL and testbench
=============================

STACK_CTRL -- requirements
Module: stack_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 32, stack entry and PC width.
REQ-002 SHALL have parameter DEPTH, default 16, entry count, power of two, minimum 2.
REQ-003 SHALL have parameter INT_VEC, default 32'h0000_0040, interrupt entry PC.
REQ-004 SHALL have ports:
- clk  in  1  clock, rising edge; one clock.
- rst  in  1  asynchronous, active-low reset.
- op  in  3  0 NOP, 1 PUSH, 2 POP, 3 CALL, 4 RET, 5 RTI.
- op_valid  in  1  op request.
- op_ready  out  1  op accepted when op_valid && op_ready.
- data_in  in  DATA_W  PUSH data, or CALL target.
- pc_in  in  DATA_W  current PC.
- flags_in  in  DATA_W  status word saved on interrupt.
- irq  in  1  level interrupt request.
- data_out  out  DATA_W  POP result.
- data_vld  out  1  one-cycle data_out strobe.
- pc_out  out  DATA_W  next PC.
- pc_load  out  1  one-cycle PC redirect strobe.
- flags_out  out  DATA_W  restored status word.
- flags_vld  out  1  one-cycle flags_out strobe.
- sp  out  $clog2(DEPTH)+1  occupied entry count.
- full, empty  out  1  sp==DEPTH, sp==0.
- int_mask  out  1  interrupts blocked.
- ovf, udf  out  1  sticky overflow and underflow errors.
- clr_err  in  1  clears ovf and udf.

Function
REQ-005 SHALL implement a LIFO: a push writes mem[sp] and increments sp; a pop reads mem[sp-1] and decrements sp.
REQ-006 SHALL complete PUSH and POP in 1 cycle; data_out and data_vld SHALL be registered and valid the cycle after acceptance.
REQ-007 SHALL on CALL push pc_in+1, drive pc_out=data_in and pulse pc_load the next cycle.
REQ-008 SHALL on RET pop into pc_out and pulse pc_load the next cycle.
REQ-009 SHALL use FSM states IDLE, INT_SAVE and RTI_PC, with op_ready=1 only in IDLE.
REQ-010 SHALL take the interrupt when irq && !int_mask in IDLE, with priority over op_valid; op_ready SHALL be 0 that cycle.
REQ-011 SHALL on interrupt entry push pc_in, set int_mask, and load pc_out=INT_VEC.
REQ-012 SHALL on RTI restore the PC by popping, clear int_mask, and pulse pc_load.
REQ-013 SHALL treat a push with full=1 as an overflow: no write, sp held, ovf set, and the op completes without a PC redirect except for interrupt entry.
REQ-014 SHALL treat a pop with empty=1 as an underflow: no read, sp held, udf set, data_vld/pc_load/flags_vld not asserted.
REQ-015 SHALL give a set priority over clr_err when the two coincide in the same cycle.
REQ-016 SHALL accept back-to-back ops on consecutive cycles in IDLE.
REQ-017 SHALL treat op=0, 6 or 7 while valid as a NOP that is accepted.

Reset
REQ-018 SHALL while rst=0 force:
- sp=0, FSM=IDLE
- int_mask, ovf, udf = 0
- all strobes = 0
- data_out, pc_out, flags_out = 0
- op_ready = 1 after release
REQ-019 SHALL NOT require mem contents to be reset.
REQ-020 SHALL abandon an in-progress INT_SAVE or RTI_PC on reset with no partial pc_load.

Configuration
REQ-021 SHALL behave as follows with STACK_CTX_SAVE_EN defined:
- Interrupt entry SHALL push pc_in in IDLE, then push flags_in in INT_SAVE, then pulse pc_load; 2 cycles.
- RTI SHALL pop flags into flags_out with flags_vld, then pop the PC in RTI_PC; 2 cycles.
- Overflow on either push sets ovf.
REQ-022 SHALL behave as follows without STACK_CTX_SAVE_EN:
- INT_SAVE and RTI_PC are never entered.
- Interrupt entry and RTI each take 1 cycle.
- flags_vld stays 0.

Structure
REQ-023 SHALL place the op encodings and the FSM state enum in shared package stack_pkg.
REQ-024 SHALL instantiate one sub-module stack_mem: a DEPTH x DATA_W register array with one synchronous write port and one asynchronous read port.

Verification (DATA_W=32, DEPTH=4)
REQ-025 SHALL verify push/pop: PUSH 11,22,33 then POP x3 -> data_out 33,22,11; sp 3->0; empty=1.
REQ-026 SHALL verify overflow: PUSH x5 -> full after the 4th push; 5th push sets ovf=1 with sp=4; clr_err clears ovf.
REQ-027 SHALL verify underflow: POP at reset -> udf=1, data_vld=0, sp=0.
REQ-028 SHALL verify call/return:
- CALL with pc_in=0x100, data_in=0x200 -> pc_out=0x200.
- RET -> pc_out=0x101, pc_load pulsed.
REQ-029 SHALL verify interrupt entry and return:
- irq with op_valid=1, pc_in=0x50, flags_in=0xA5 -> op_ready=0, pc_out=0x40, int_mask=1.
- RTI -> flags_out=0xA5 (EN defined), pc_out=0x50, int_mask=0.
REQ-030 SHALL verify reset mid-operation: assert rst in INT_SAVE -> no pc_load, sp=0, FSM=IDLE.

Source files
------------

// File: rtl/stack_pkg.sv
// Shared definitions for the hardware stack controller: op encodings and FSM states.
package stack_pkg;

  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_PUSH = 3'd1,
    OP_POP  = 3'd2,
    OP_CALL = 3'd3,
    OP_RET  = 3'd4,
    OP_RTI  = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    INT_SAVE = 2'd1,
    RTI_PC   = 2'd2
  } state_e;

endpackage

// File: rtl/stack_mem.sv
// Stack storage: DEPTH x DATA_W register array, one synchronous write port,
// one asynchronous read port. Contents are not reset.
module stack_mem #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DATA_W-1:0]        rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write the addressed entry on an enabled clock edge.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Top-of-stack read is combinational so a pop completes in one cycle.
  always_comb begin
    rdata = mem[raddr];
  end

endmodule

// File: rtl/stack_ctrl.sv
// Hardware call/data stack controller with interrupt entry and return.
// Optional feature: define STACK_CTX_SAVE_EN to also save/restore the status
// word on interrupt entry/RTI (two-cycle sequences via INT_SAVE / RTI_PC).
module stack_ctrl
  import stack_pkg::*;
#(
  parameter int                 DATA_W  = 32,
  parameter int                 DEPTH   = 16,
  parameter logic [DATA_W-1:0]  INT_VEC = DATA_W'(32'h0000_0040)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [2:0]             op,
  input  logic                   op_valid,
  output logic                   op_ready,
  input  logic [DATA_W-1:0]      data_in,
  input  logic [DATA_W-1:0]      pc_in,
  input  logic [DATA_W-1:0]      flags_in,
  input  logic                   irq,
  output logic [DATA_W-1:0]      data_out,
  output logic                   data_vld,
  output logic [DATA_W-1:0]      pc_out,
  output logic                   pc_load,
  output logic [DATA_W-1:0]      flags_out,
  output logic                   flags_vld,
  output logic [$clog2(DEPTH):0] sp,
  output logic                   full,
  output logic                   empty,
  output logic                   int_mask,
  output logic                   ovf,
  output logic                   udf,
  input  logic                   clr_err
);

  localparam int AW  = $clog2(DEPTH);
  localparam int SPW = AW + 1;

  state_e            state;
  logic              take_irq, accept;
  logic              push_req, pop_req, wr_en, rd_ok;
  logic [DATA_W-1:0] wdata, rdata;
  logic [AW-1:0]     waddr, raddr;

  assign full     = (sp == SPW'(DEPTH));
  assign empty    = (sp == '0);
  // Interrupt wins over a pending op; the op is simply not accepted that cycle.
  assign take_irq = (state == IDLE) && irq && !int_mask;
  assign op_ready = (state == IDLE) && !take_irq;
  assign accept   = op_valid && op_ready;
  assign waddr    = sp[AW-1:0];
  assign raddr    = sp[AW-1:0] - AW'(1);
  assign wr_en    = push_req && !full;
  assign rd_ok    = pop_req && !empty;

  // Decide whether this cycle pushes or pops, and what is pushed.
  always_comb begin
    push_req = 1'b0;
    pop_req  = 1'b0;
    wdata    = data_in;
    case (state)
      IDLE: begin
        if (take_irq) begin
          push_req = 1'b1;
          wdata    = pc_in;
        end else if (accept) begin
          case (op)
            OP_PUSH: push_req = 1'b1;
            OP_CALL: begin
              push_req = 1'b1;
              wdata    = pc_in + DATA_W'(1);
            end
            OP_POP, OP_RET, OP_RTI: pop_req = 1'b1;
            default: ;
          endcase
        end
      end
      INT_SAVE: begin
        push_req = 1'b1;
        wdata    = flags_in;
      end
      RTI_PC:  pop_req = 1'b1;
      default: ;
    endcase
  end

  stack_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (wr_en),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (raddr),
    .rdata (rdata)
  );

  // Control FSM: stack pointer, sticky errors, interrupt mask and registered strobes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      sp        <= '0;
      int_mask  <= 1'b0;
      ovf       <= 1'b0;
      udf       <= 1'b0;
      data_out  <= '0;
      data_vld  <= 1'b0;
      pc_out    <= '0;
      pc_load   <= 1'b0;
      flags_out <= '0;
      flags_vld <= 1'b0;
    end else begin
      data_vld  <= 1'b0;
      pc_load   <= 1'b0;
      flags_vld <= 1'b0;

      if (wr_en)      sp <= sp + SPW'(1);
      else if (rd_ok) sp <= sp - SPW'(1);

      if (push_req && full) ovf <= 1'b1;
      else if (clr_err)     ovf <= 1'b0;
      if (pop_req && empty) udf <= 1'b1;
      else if (clr_err)     udf <= 1'b0;

      case (state)
        IDLE: begin
          if (take_irq) begin
            int_mask <= 1'b1;
`ifdef STACK_CTX_SAVE_EN
            state    <= INT_SAVE;
`else
            pc_out   <= INT_VEC;
            pc_load  <= 1'b1;
`endif
          end else if (accept) begin
            case (op)
              OP_POP: if (rd_ok) begin
                data_out <= rdata;
                data_vld <= 1'b1;
              end
              OP_CALL: if (wr_en) begin
                pc_out  <= data_in;
                pc_load <= 1'b1;
              end
              OP_RET: if (rd_ok) begin
                pc_out  <= rdata;
                pc_load <= 1'b1;
              end
              OP_RTI: begin
`ifdef STACK_CTX_SAVE_EN
                if (rd_ok) begin
                  flags_out <= rdata;
                  flags_vld <= 1'b1;
                end
                state <= RTI_PC;
`else
                int_mask <= 1'b0;
                if (rd_ok) begin
                  pc_out  <= rdata;
                  pc_load <= 1'b1;
                end
`endif
              end
              default: ;
            endcase
          end
        end
        INT_SAVE: begin
          pc_out  <= INT_VEC;
          pc_load <= 1'b1;
          state   <= IDLE;
        end
        RTI_PC: begin
          int_mask <= 1'b0;
          if (rd_ok) begin
            pc_out  <= rdata;
            pc_load <= 1'b1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stack_ctrl.sv
// Self-checking bench for stack_ctrl (DATA_W=32, DEPTH=4): a queue-based
// reference model checked every cycle, plus hand-computed literal checks.
module tb_stack_ctrl;

  localparam int          DATA_W  = 32;
  localparam int          DEPTH   = 4;
  localparam logic [31:0] INT_VEC = 32'h40;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  op = '0;
  logic        op_valid = 1'b0;
  logic        op_ready;
  logic [31:0] data_in = '0, pc_in = '0, flags_in = '0;
  logic        irq = 1'b0;
  logic [31:0] data_out, pc_out, flags_out;
  logic        data_vld, pc_load, flags_vld;
  logic [2:0]  sp;
  logic        full, empty, int_mask, ovf, udf;
  logic        clr_err = 1'b0;

  stack_ctrl #(
    .DATA_W  (DATA_W),
    .DEPTH   (DEPTH),
    .INT_VEC (INT_VEC)
  ) dut (
    .clk (clk), .rst (rst), .op (op), .op_valid (op_valid), .op_ready (op_ready),
    .data_in (data_in), .pc_in (pc_in), .flags_in (flags_in), .irq (irq),
    .data_out (data_out), .data_vld (data_vld), .pc_out (pc_out), .pc_load (pc_load),
    .flags_out (flags_out), .flags_vld (flags_vld), .sp (sp), .full (full),
    .empty (empty), .int_mask (int_mask), .ovf (ovf), .udf (udf), .clr_err (clr_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  // ---------------- reference model ----------------
  logic [31:0] stk[$];
  bit          m_mask, m_ovf, m_udf, so, su;
  int          pend;  // 0 none, 1 flags push pending, 2 PC pop pending
  logic [31:0] e_data_out, e_pc_out, e_flags_out;
  bit          e_data_vld, e_pc_load, e_flags_vld;

  function automatic bit mpush(input logic [31:0] d);
    if (stk.size() >= DEPTH) begin
      so = 1'b1;
      return 1'b0;
    end
    stk.push_back(d);
    return 1'b1;
  endfunction

  function automatic bit mpop(output logic [31:0] d);
    d = '0;
    if (stk.size() == 0) begin
      su = 1'b1;
      return 1'b0;
    end
    d = stk.pop_back();
    return 1'b1;
  endfunction

  always @(posedge clk or negedge rst) begin
    logic [31:0] v;
    if (!rst) begin
      stk.delete();
      m_mask = 0; m_ovf = 0; m_udf = 0; pend = 0;
      e_data_out = '0; e_pc_out = '0; e_flags_out = '0;
      e_data_vld = 0; e_pc_load = 0; e_flags_vld = 0;
    end else begin
      e_data_vld = 0; e_pc_load = 0; e_flags_vld = 0;
      so = 0; su = 0;
      if (pend == 1) begin
        void'(mpush(flags_in));
        e_pc_out = INT_VEC; e_pc_load = 1; pend = 0;
      end else if (pend == 2) begin
        if (mpop(v)) begin e_pc_out = v; e_pc_load = 1; end
        m_mask = 0; pend = 0;
      end else if (irq && !m_mask) begin
        void'(mpush(pc_in));
        m_mask = 1;
`ifdef STACK_CTX_SAVE_EN
        pend = 1;
`else
        e_pc_out = INT_VEC; e_pc_load = 1;
`endif
      end else if (op_valid) begin
        case (op)
          3'd1: void'(mpush(data_in));
          3'd2: if (mpop(v)) begin e_data_out = v; e_data_vld = 1; end
          3'd3: if (mpush(pc_in + 1)) begin e_pc_out = data_in; e_pc_load = 1; end
          3'd4: if (mpop(v)) begin e_pc_out = v; e_pc_load = 1; end
          3'd5: begin
`ifdef STACK_CTX_SAVE_EN
            if (mpop(v)) begin e_flags_out = v; e_flags_vld = 1; end
            pend = 2;
`else
            if (mpop(v)) begin e_pc_out = v; e_pc_load = 1; end
            m_mask = 0;
`endif
          end
          default: ;
        endcase
      end
      m_ovf = so ? 1'b1 : (clr_err ? 1'b0 : m_ovf);
      m_udf = su ? 1'b1 : (clr_err ? 1'b0 : m_udf);
    end
  end

  // Every-cycle comparison against the model, away from the clock edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("op_ready",  32'(op_ready),  32'(pend == 0 && !(irq && !m_mask)));
      chk("sp",        32'(sp),        32'(stk.size()));
      chk("full",      32'(full),      32'(stk.size() == DEPTH));
      chk("empty",     32'(empty),     32'(stk.size() == 0));
      chk("int_mask",  32'(int_mask),  32'(m_mask));
      chk("ovf",       32'(ovf),       32'(m_ovf));
      chk("udf",       32'(udf),       32'(m_udf));
      chk("data_vld",  32'(data_vld),  32'(e_data_vld));
      chk("data_out",  data_out,       e_data_out);
      chk("pc_load",   32'(pc_load),   32'(e_pc_load));
      chk("pc_out",    pc_out,         e_pc_out);
      chk("flags_vld", 32'(flags_vld), 32'(e_flags_vld));
      chk("flags_out", flags_out,      e_flags_out);
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input bit v, input logic [2:0] o, input logic [31:0] d,
                       input logic [31:0] pc, input logic [31:0] fl,
                       input bit ir, input bit ce);
    op_valid = v; op = o; data_in = d; pc_in = pc; flags_in = fl; irq = ir; clr_err = ce;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input bit v, input logic [2:0] o, input logic [31:0] d);
    drive(v, o, d, 32'h0, 32'h0, 1'b0, 1'b0);
    step();
  endtask

  initial begin
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    chk_en = 1'b1;
    chk("rst_op_ready", 32'(op_ready), 1);
    chk("rst_sp", 32'(sp), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_pc_out", pc_out, 0);

    // Underflow from reset, then clear.
    cyc(1, 3'd2, 0);
    chk("udf_set", 32'(udf), 1);
    chk("udf_no_vld", 32'(data_vld), 0);
    chk("udf_sp", 32'(sp), 0);
    drive(0, 3'd0, 0, 0, 0, 0, 1); step();
    chk("udf_clr", 32'(udf), 0);

    // LIFO order, back-to-back.
    cyc(1, 3'd1, 32'd11);
    cyc(1, 3'd1, 32'd22);
    cyc(1, 3'd1, 32'd33);
    chk("push3_sp", 32'(sp), 3);
    cyc(1, 3'd2, 0);
    chk("pop1_data", data_out, 32'd33);
    chk("pop1_vld", 32'(data_vld), 1);
    cyc(1, 3'd2, 0);
    chk("pop2_data", data_out, 32'd22);
    cyc(1, 3'd2, 0);
    chk("pop3_data", data_out, 32'd11);
    chk("pop3_empty", 32'(empty), 1);
    cyc(0, 3'd0, 0);
    chk("vld_one_cycle", 32'(data_vld), 0);

    // Overflow, set-over-clear priority, clear.
    for (int i = 1; i <= 4; i++) cyc(1, 3'd1, 32'hA0 + 32'(i));
    chk("full_at4", 32'(full), 1);
    cyc(1, 3'd1, 32'hA5);
    chk("ovf_set", 32'(ovf), 1);
    chk("ovf_sp", 32'(sp), 4);
    drive(1, 3'd1, 32'hA6, 0, 0, 0, 1); step();
    chk("ovf_set_wins", 32'(ovf), 1);
    drive(0, 3'd0, 0, 0, 0, 0, 1); step();
    chk("ovf_clr", 32'(ovf), 0);
    cyc(1, 3'd2, 0);
    chk("ovf_top_kept", data_out, 32'hA4);
    for (int i = 0; i < 3; i++) cyc(1, 3'd2, 0);
    // Reserved op codes are accepted as NOPs.
    drive(1, 3'd6, 32'h99, 0, 0, 0, 0); #1;
    chk("nop6_ready", 32'(op_ready), 1);
    step();
    cyc(1, 3'd7, 32'h99);
    chk("nop_sp", 32'(sp), 0);

    // CALL / RET.
    drive(1, 3'd3, 32'h200, 32'h100, 0, 0, 0); step();
    chk("call_pc", pc_out, 32'h200);
    chk("call_load", 32'(pc_load), 1);
    cyc(0, 3'd0, 0);
    chk("call_load_pulse", 32'(pc_load), 0);
    cyc(1, 3'd4, 0);
    chk("ret_pc", pc_out, 32'h101);
    chk("ret_load", 32'(pc_load), 1);

    // Interrupt entry beats a valid op.
    drive(1, 3'd1, 32'h77, 32'h50, 32'hA5, 1, 0); #1;
    chk("irq_not_ready", 32'(op_ready), 0);
    step();
`ifdef STACK_CTX_SAVE_EN
    chk("irq_mask", 32'(int_mask), 1);
    drive(0, 3'd0, 0, 32'h50, 32'hA5, 0, 0); step();
`endif
    chk("irq_pc", pc_out, 32'h40);
    chk("irq_load", 32'(pc_load), 1);
    chk("irq_mask2", 32'(int_mask), 1);
    // Masked: irq ignored, ops flow.
    drive(1, 3'd1, 32'h77, 32'h60, 0, 1, 0); step();
    cyc(1, 3'd2, 0);
    chk("masked_pop", data_out, 32'h77);
    cyc(1, 3'd5, 0);
`ifdef STACK_CTX_SAVE_EN
    chk("rti_flags", flags_out, 32'hA5);
    chk("rti_flags_vld", 32'(flags_vld), 1);
    cyc(0, 3'd0, 0);
`endif
    chk("rti_pc", pc_out, 32'h50);
    chk("rti_load", 32'(pc_load), 1);
    chk("rti_unmask", 32'(int_mask), 0);

    // Reset during interrupt entry.
    cyc(1, 3'd1, 32'h12);
    drive(0, 3'd0, 0, 32'h80, 32'h5A, 1, 0); step();
    drive(0, 3'd0, 0, 0, 0, 0, 0);
    rst = 1'b0; #1;
    chk("mid_rst_sp", 32'(sp), 0);
    chk("mid_rst_load", 32'(pc_load), 0);
    step();
    chk("mid_rst_no_load", 32'(pc_load), 0);
    chk("mid_rst_mask", 32'(int_mask), 0);
    rst = 1'b1;
    step();
    chk("post_rst_ready", 32'(op_ready), 1);
    cyc(1, 3'd1, 32'h3C);
    cyc(1, 3'd2, 0);
    chk("post_rst_pop", data_out, 32'h3C);
    cyc(0, 3'd0, 0);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
